// File: rtl/sub_chain8_pkg.sv
// Shared types and constants for the sub_chain8 limb-stream subtractor.
package sub_chain8_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_MAX_LIMBS = 16;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    // Limb-index counter width; never narrower than one bit.
    function automatic int unsigned calc_cw(input int unsigned max_limbs);
        if (max_limbs <= 32'd1) begin
            return 32'd1;
        end
        return 32'(unsigned'($clog2(max_limbs)));
    endfunction

endpackage

// File: rtl/sub_limb.sv
// One-limb subtract with borrow: {bout, d} = a - b - bi.
module sub_limb
    import sub_chain8_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    // Extend by one bit so the top bit of the result is the borrow-out.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};

endmodule

// File: rtl/sub_chain8.sv
// Registered multi-precision subtractor over LS-first limb streams.
// Optional feature macro: SUB_CHAIN8_ZERO_EN builds the operand-wide zero flag;
// without it, zero is tied low.
module sub_chain8
    import sub_chain8_pkg::*;
#(
    parameter  int unsigned WIDTH     = DEF_WIDTH,
    parameter  int unsigned MAX_LIMBS = DEF_MAX_LIMBS,
    localparam int unsigned CW        = calc_cw(MAX_LIMBS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             out_last,
    output logic             zero,
    output logic [CW-1:0]    limb_idx,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic             borrow_q;
    logic             borrow_nxt;
    logic             out_valid_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             bout_nxt;
    logic             out_last_nxt;
    logic [CW-1:0]    limb_idx_nxt;
    logic             err_nxt;

    logic             take;
    logic             start;
    logic             bi;
    logic [WIDTH-1:0] d_c;
    logic             bout_c;
    logic [CW:0]      idx_inc;
    logic             idx_wrap;

    // Single output register: accept whenever it is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready;

    // A limb starts a fresh operand when idle or when flagged first.
    assign start = (state == ST_IDLE) || in_first;
    assign bi    = start ? bin : borrow_q;

    assign idx_inc  = {1'b0, limb_idx} + (CW+1)'(1);
    assign idx_wrap = (idx_inc == (CW+1)'(MAX_LIMBS));

    sub_limb #(
        .WIDTH (WIDTH)
    ) u_limb (
        .a    (a),
        .b    (b),
        .bi   (bi),
        .d    (d_c),
        .bout (bout_c)
    );

    // Next-state and result-register update.
    always_comb begin
        state_nxt     = state;
        borrow_nxt    = borrow_q;
        out_valid_nxt = out_valid;
        d_nxt         = d;
        bout_nxt      = bout;
        out_last_nxt  = out_last;
        limb_idx_nxt  = limb_idx;
        err_nxt       = err;

        if (take) begin
            out_valid_nxt = 1'b1;
            d_nxt         = d_c;
            bout_nxt      = bout_c;
            borrow_nxt    = bout_c;
            out_last_nxt  = in_last;
            state_nxt     = in_last ? ST_IDLE : ST_BUSY;

            if ((state == ST_IDLE && !in_first) || (state == ST_BUSY && in_first)) begin
                err_nxt = 1'b1;
            end

            if (start) begin
                limb_idx_nxt = '0;
            end else if (idx_wrap) begin
                limb_idx_nxt = '0;
                err_nxt      = 1'b1;
            end else begin
                limb_idx_nxt = idx_inc[CW-1:0];
            end
        end else if (out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            borrow_q  <= 1'b0;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            out_last  <= 1'b0;
            limb_idx  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            borrow_q  <= borrow_nxt;
            out_valid <= out_valid_nxt;
            d         <= d_nxt;
            bout      <= bout_nxt;
            out_last  <= out_last_nxt;
            limb_idx  <= limb_idx_nxt;
            err       <= err_nxt;
        end
    end

`ifdef SUB_CHAIN8_ZERO_EN
    logic zacc_q;
    logic zacc_nxt;
    logic zero_nxt;

    // Running all-zero tracker, reseeded on each operand start.
    always_comb begin
        zacc_nxt = zacc_q;
        zero_nxt = zero;
        if (take) begin
            zacc_nxt = (start || zacc_q) && (d_c == '0);
            zero_nxt = in_last && zacc_nxt;
        end
    end

    // Zero-flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            zacc_q <= 1'b0;
            zero   <= 1'b0;
        end else begin
            zacc_q <= zacc_nxt;
            zero   <= zero_nxt;
        end
    end
`else
    assign zero = 1'b0;
`endif

endmodule
